ac_match_reporter: RTL
======================

# ac_match_reporter

Downstream stage of the Aho-Corasick matcher `TOP`. It takes the per-byte match vector produced by the automaton, tags each hit with the stream position of the byte that completed it, and serialises multiple simultaneous hits into one record per cycle. Records are buffered in a small FIFO and drained by the host through a valid/ready handshake. Backpressure to the matcher is applied through `IN_READY` whenever a hit is still being serialised.

## Interface
- `NPAT`, 4: number of patterns; one match bit each.
- `POS_W`, 16: width of the byte-position counter.
- `DEPTH`, 8: record FIFO depth; must be a power of 2 and at least 2.
- `ID_W`, `$clog2(NPAT)` (derived, min 1): pattern-ID width.

Ports:
- `CLK` in 1: sole clock, rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `BYTE_EN` in 1: the matcher consumed one byte this cycle.
- `MATCH` in `NPAT`: patterns ending at that byte; qualified by `BYTE_EN`.
- `IN_READY` out 1: block accepts `BYTE_EN`. A byte is accepted on `BYTE_EN && IN_READY`.
- `REC_VALID` out 1: FIFO head holds a record.
- `REC_READY` in 1: host pops the head on `REC_VALID && REC_READY`.
- `REC_ID` out `ID_W`: pattern index of the head record.
- `REC_POS` out `POS_W`: position of the last byte of the match.
- `MATCH_CNT` out 16: records pushed since reset; saturates at 0xFFFF.

## Operation
- **Position counter `pos`.**
  - Reset value is 0.
  - The accepted byte is tagged with the current `pos`; `pos` then increments.
  - `pos` wraps modulo 2^`POS_W`.
- **FSM states.**
  - IDLE: `IN_READY`=1.
  - DRAIN: `IN_READY`=0.
  - `IN_READY` is a combinational decode of the state only.
- **IDLE transitions.**
  - Accepted byte with `MATCH`==0: stay in IDLE; the only effect is the `pos` increment.
  - Accepted byte with `MATCH`!=0: latch `pend`←`MATCH` and `pend_pos`←tag, then go to DRAIN.
  - `MATCH` is ignored when `BYTE_EN`=0 or `IN_READY`=0.
- **DRAIN behaviour.**
  - Each cycle with push permission, push {lowest set index of `pend`, `pend_pos`} and clear that bit.
  - Push permission = FIFO not full, or FIFO full with a pop in the same cycle.
  - When the pushed bit was the last one set, return to IDLE; `IN_READY` rises on the next cycle.
  - Without permission, hold state and `pend` unchanged.
- **Input throughput.** A byte with k hits costs 1+k cycles of input bandwidth.
- **FIFO.**
  - Push and pop may occur in the same cycle at any occupancy; when full, push is legal only alongside a pop.
  - A pop on empty is ignored.
  - No record is ever dropped: backpressure covers every full condition.
- **MATCH_CNT.** Increments by 1 per push and saturates at 0xFFFF.
- **Reset values of outputs.** `IN_READY`=1, `REC_VALID`=0, `REC_ID`=0, `REC_POS`=0, `MATCH_CNT`=0.
- **Reset of internal state.** `pend`=0, `pos`=0, FIFO empty, state IDLE.
- **Reset mid-operation.** `RST` during DRAIN or with a non-empty FIFO discards all pending and buffered records; nothing is emitted afterwards from pre-reset data.

## Timing
- Byte accepted in cycle N with hits: first push at N+1, `REC_VALID` high at N+2 (registered FIFO head).
- The i-th hit (0-based, ascending pattern index) is pushed at N+1+i when the FIFO never fills.
- `IN_READY` is low from N+1 through N+k and high again at N+k+1.
- Pop at edge M: the next head is visible at M+1; `REC_VALID` falls at M+1 if the FIFO is then empty.
- `REC_ID` and `REC_POS` hold their last value while `REC_VALID`=0.

## Structure
- Shared package `ac_pkg`:
  - default `NPAT` and `POS_W`;
  - `ac_rec_t` packed struct {id, pos};
  - lowest-set-bit function for the priority pick.
- Sub-module `ac_rec_fifo`: synchronous `DEPTH`×`ac_rec_t` FIFO with full/empty flags, registered head, and same-cycle push/pop.
- Top level holds the FSM, `pos`, `pend`/`pend_pos`, and `MATCH_CNT`.

## Test plan
- **Reset.** `RST`=1 for 2 cycles → `IN_READY`=1, `REC_VALID`=0, `MATCH_CNT`=0, `REC_ID`=0, `REC_POS`=0.
- **Single hit.** 4 bytes, `MATCH`=4'b0100 on byte 2, `REC_READY`=1 → one record ID=2 POS=2; `IN_READY` low exactly 1 cycle; `MATCH_CNT`=1.
- **Multi-hit ordering.** `MATCH`=4'b1011 on byte 0 → records (0,0), (1,0), (3,0) in that order; `IN_READY` low 3 cycles.
- **Full FIFO.** `REC_READY`=0, `DEPTH`=8, three bytes each with `MATCH`=4'b1111:
  - 8 records stored and `IN_READY` stuck low;
  - raise `REC_READY` → all 12 records arrive, positions 0,0,0,0,1,1,1,1,2,2,2,2;
  - `MATCH_CNT`=12; no loss.
- **Position wrap.** `POS_W`=4, 17 bytes, `MATCH`=4'b0001 on byte 16 → record ID=0 POS=0.
- **Reset mid-drain.** Assert `RST` during DRAIN with 3 records buffered → `REC_VALID`=0 next cycle; no stale record appears; the next byte is tagged POS=0.

Source files
------------

// File: rtl/ac_match_reporter_pkg.sv
// Shared types and helpers for the Aho-Corasick match reporter: default
// geometry, the FSM state encoding, the record layout and the priority pick.
package ac_pkg;

  localparam int AC_NPAT  = 4;
  localparam int AC_POS_W = 16;
  localparam int AC_ID_W  = (AC_NPAT > 1) ? $clog2(AC_NPAT) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } ac_state_t;

  typedef struct packed {
    logic [AC_ID_W-1:0]  id;
    logic [AC_POS_W-1:0] pos;
  } ac_rec_t;

  // Index of the lowest set bit; callers only use it on a non-zero vector.
  function automatic int unsigned lowest_set(input logic [31:0] vec);
    lowest_set = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) lowest_set = i;
    end
  endfunction

endpackage

// File: rtl/ac_match_reporter_fifo.sv
// Record FIFO with a registered head: the head register only changes when a
// new record becomes visible, so the outputs hold their last value when empty.
module ac_rec_fifo
  import ac_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type REC_T = ac_rec_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  REC_T din,
  output REC_T head,
  output logic valid,
  output logic full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  REC_T             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push;
  logic             do_pop;
  REC_T             head_nxt;

  always_comb begin
    do_pop     = pop && (count != '0);
    do_push    = push && ((count != CNT_W'(DEPTH)) || do_pop);
    rd_ptr_nxt = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_nxt  = count + CNT_W'(do_push) - CNT_W'(do_pop);
    head_nxt   = head;
    // The slot being written this cycle is not in mem yet, so bypass it.
    if (count_nxt != '0) begin
      head_nxt = (do_push && (rd_ptr_nxt == wr_ptr)) ? din : mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      head   <= head_nxt;
    end
  end

  assign valid = (count != '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/ac_match_reporter.sv
// Tags each match hit with its byte position and serialises simultaneous hits
// into one record per cycle, stalling the matcher while a hit set drains.
module ac_match_reporter
  import ac_pkg::*;
#(
  parameter int  NPAT  = AC_NPAT,
  parameter int  POS_W = AC_POS_W,
  parameter int  DEPTH = 8,
  localparam int ID_W  = (NPAT > 1) ? $clog2(NPAT) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BYTE_EN,
  input  logic [NPAT-1:0]  MATCH,
  output logic             IN_READY,
  output logic             REC_VALID,
  input  logic             REC_READY,
  output logic [ID_W-1:0]  REC_ID,
  output logic [POS_W-1:0] REC_POS,
  output logic [15:0]      MATCH_CNT
);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [POS_W-1:0] pos;
  } rec_t;

  ac_state_t        state;
  ac_state_t        state_nxt;
  logic [POS_W-1:0] pos;
  logic [NPAT-1:0]  pend;
  logic [NPAT-1:0]  pend_nxt;
  logic [POS_W-1:0] pend_pos;
  logic [15:0]      match_cnt;
  logic             accept;
  logic             push;
  logic             pop;
  logic             fifo_full;
  rec_t             push_rec;
  rec_t             head;

  assign pop = REC_VALID && REC_READY;

  always_comb begin
    state_nxt    = state;
    pend_nxt     = pend;
    push         = 1'b0;
    IN_READY     = (state == ST_IDLE);
    accept       = BYTE_EN && IN_READY;
    push_rec.id  = ID_W'(lowest_set(32'(pend)));
    push_rec.pos = pend_pos;
    case (state)
      ST_IDLE: begin
        if (accept && (MATCH != '0)) begin
          pend_nxt  = MATCH;
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A full FIFO still takes a record when the host pops in the same cycle.
        if (!fifo_full || pop) begin
          push     = 1'b1;
          pend_nxt = pend & (pend - NPAT'(1));
          if (pend_nxt == '0) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      pos       <= '0;
      pend      <= '0;
      pend_pos  <= '0;
      match_cnt <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      if (accept) begin
        pos <= pos + POS_W'(1);
        if (MATCH != '0) pend_pos <= pos;
      end
      if (push && (match_cnt != 16'hFFFF)) match_cnt <= match_cnt + 16'd1;
    end
  end

  ac_rec_fifo #(
    .DEPTH (DEPTH),
    .REC_T (rec_t)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (push_rec),
    .head  (head),
    .valid (REC_VALID),
    .full  (fifo_full)
  );

  assign REC_ID    = head.id;
  assign REC_POS   = head.pos;
  assign MATCH_CNT = match_cnt;

endmodule
